ram_arbiter: RTL and testbench

Round-robin arbiter and sequencer sitting in front of the single-port synchronous `ram` block. It shares one RAM port among `NUM_REQ` requesters using a req/gnt handshake and issues at most one access per cycle. Read data returns tagged with the requester id. An optional post-reset clear sequence zero-fills the memory before any grant is issued.

---
 rtl/ram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter/sequencer sharing one synchronous RAM port
// Optional post-reset zero-fill of the RAM is built when RAM_ARB_CLEAR_EN is defined.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 10,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADD_WIDTH-1:0]    req_add,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            rsp_valid,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            init_done,
    output logic                            ram_cs,
    output logic                            ram_we,
    output logic                            ram_oe,
    output logic [ADD_WIDTH-1:0]            ram_add,
    output logic [DATA_WIDTH-1:0]           ram_data_in,
    input  logic [DATA_WIDTH-1:0]           ram_data_out
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ID_WIDTH-1:0]     r_ptr;
    logic                    r_init_done;
    logic                    w_init_set;

    logic                    r_cs;
    logic                    r_we;
    logic                    r_oe;
    logic [ADD_WIDTH-1:0]    r_add;
    logic [DATA_WIDTH-1:0]   r_data_in;

    logic                    w_cs;
    logic                    w_we;
    logic                    w_oe;
    logic [ADD_WIDTH-1:0]    w_add;
    logic [DATA_WIDTH-1:0]   w_data_in;

    logic                    r_tag_v1;
    logic                    r_tag_v2;
    logic [ID_WIDTH-1:0]     r_tag_id1;
    logic [ID_WIDTH-1:0]     r_tag_id2;

    logic                    w_rr_hit;
    logic [ID_WIDTH-1:0]     w_rr_id;
    logic                    w_accept;
    logic                    w_sel_we;

`ifdef RAM_ARB_CLEAR_EN
    localparam int RAM_SIZE = 1 << ADD_WIDTH;
    logic [ADD_WIDTH-1:0]    r_clr_cnt;
    logic                    w_clr_last;

    assign w_clr_last = (r_clr_cnt == ADD_WIDTH'(RAM_SIZE - 1));
`endif

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int v_idx;
        w_rr_hit = 1'b0;
        w_rr_id  = '0;
        v_idx    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            v_idx = (int'(r_ptr) + off) % NUM_REQ;
            if (!w_rr_hit && req[v_idx]) begin
                w_rr_hit = 1'b1;
                w_rr_id  = ID_WIDTH'(v_idx);
            end
        end
    end

    assign w_accept = (r_state == ST_ARB) && r_init_done && w_rr_hit;
    assign gnt      = w_accept ? (NUM_REQ'(1) << w_rr_id) : '0;
    assign w_sel_we = req_we[w_rr_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef RAM_ARB_CLEAR_EN
            r_state <= ST_CLEAR;
`else
            r_state <= ST_ARB;
`endif
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
`ifdef RAM_ARB_CLEAR_EN
        if (r_state == ST_CLEAR && w_clr_last) begin
            w_state_next = ST_ARB;
        end
`endif
    end

    always_comb begin
        w_cs       = 1'b0;
        w_we       = 1'b0;
        w_oe       = 1'b0;
        w_add      = r_add;
        w_data_in  = r_data_in;
`ifdef RAM_ARB_CLEAR_EN
        w_init_set = (r_state == ST_CLEAR) && w_clr_last;
        if (r_state == ST_CLEAR) begin
            w_cs      = 1'b1;
            w_we      = 1'b1;
            w_add     = r_clr_cnt;
            w_data_in = '0;
        end else
`else
        w_init_set = 1'b1;
`endif
        if (w_accept) begin
            w_cs  = 1'b1;
            w_we  = w_sel_we;
            w_oe  = !w_sel_we;
            w_add = req_add[w_rr_id*ADD_WIDTH +: ADD_WIDTH];
            if (w_sel_we) begin
                w_data_in = req_data[w_rr_id*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= ID_WIDTH'(NUM_REQ - 1);
            r_init_done <= 1'b0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_oe        <= 1'b0;
            r_add       <= '0;
            r_data_in   <= '0;
            r_tag_v1    <= 1'b0;
            r_tag_v2    <= 1'b0;
            r_tag_id1   <= '0;
            r_tag_id2   <= '0;
        end else begin
            r_init_done <= r_init_done | w_init_set;
            r_cs        <= w_cs;
            r_we        <= w_we;
            r_oe        <= w_oe;
            r_add       <= w_add;
            r_data_in   <= w_data_in;
            if (w_accept) begin
                r_ptr <= w_rr_id;
            end
            // Tag stage 2 lines up with the RAM's registered read data.
            r_tag_v1    <= w_accept && !w_sel_we;
            r_tag_id1   <= w_rr_id;
            r_tag_v2    <= r_tag_v1;
            r_tag_id2   <= r_tag_id1;
        end
    end

`ifdef RAM_ARB_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end
`endif

    assign init_done   = r_init_done;
    assign ram_cs      = r_cs;
    assign ram_we      = r_we;
    assign ram_oe      = r_oe;
    assign ram_add     = r_add;
    assign ram_data_in = r_data_in;
    assign rsp_valid   = r_tag_v2;
    assign rsp_id      = r_tag_id2;
    assign rsp_data    = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a RAM model and reference model
module tb_ram_arbiter;
    localparam int DW       = 32;
    localparam int AW       = 6;
    localparam int NR       = 4;
    localparam int IW       = 2;
    localparam int RAM_SIZE = 1 << AW;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NR-1:0]      req = '0;
    logic [NR-1:0]      req_we = '0;
    logic [NR*AW-1:0]   req_add = '0;
    logic [NR*DW-1:0]   req_data = '0;
    logic [NR-1:0]      gnt;
    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               init_done;
    logic               ram_cs, ram_we, ram_oe;
    logic [AW-1:0]      ram_add;
    logic [DW-1:0]      ram_data_in;
    logic [DW-1:0]      ram_data_out;

    ram_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_add(req_add),
        .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .init_done(init_done), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_oe(ram_oe), .ram_add(ram_add), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM seen by the arbiter
    logic [DW-1:0] ram_mem [RAM_SIZE];
    logic [DW-1:0] ram_q = '0;
    logic          mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < RAM_SIZE; i++) ram_mem[i] <= '0;
        if (ram_cs && ram_we) ram_mem[ram_add] <= ram_data_in;
        if (ram_cs && ram_oe) ram_q <= ram_mem[ram_add];
    end
    assign ram_data_out = ram_q;

    typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
    typedef struct { logic [NR-1:0] r; logic [NR-1:0] g; } vec_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            m_ptr;
    logic [DW-1:0] m_mem [RAM_SIZE];
    rsp_t          m_q[$];
    logic          m_cs, m_we, m_oe;
    logic [AW-1:0] m_add;
    logic [DW-1:0] m_din;
    int            wait_cnt [NR];
    logic          rsp_got;
    int            rsp_got_id, rsp_got_cyc;
    logic [DW-1:0] rsp_got_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Winner is the requester at the smallest circular distance past the last winner.
    function automatic logic [NR-1:0] model_gnt(input logic [NR-1:0] r);
        int best = -1;
        int bd = NR;
        for (int i = 0; i < NR; i++) begin
            if (r[i] && ((i - m_ptr - 1 + 2 * NR) % NR) < bd) begin
                bd = (i - m_ptr - 1 + 2 * NR) % NR;
                best = i;
            end
        end
        return (best < 0) ? '0 : (NR'(1) << best);
    endfunction

    task automatic cycle(input logic [NR-1:0] r, input logic [NR-1:0] w,
                         input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                         output logic [NR-1:0] g);
        logic [NR-1:0] eg;
        int wi;
        logic exp_v;
        req = r; req_we = w; req_add = a; req_data = d;
        #1;
        eg = model_gnt(r);
        chk("gnt", gnt, eg);
        g = gnt;
        @(posedge clk);
        #1;
        cyc++;
        wi = -1;
        for (int i = 0; i < NR; i++) if (eg[i]) wi = i;
        m_cs = 1'b0; m_we = 1'b0; m_oe = 1'b0;
        if (wi >= 0) begin
            chk("fairness_wait", 64'(wait_cnt[wi] < NR), 64'(1));
            m_cs = 1'b1; m_we = w[wi]; m_oe = !w[wi];
            m_add = a[wi*AW +: AW];
            if (w[wi]) begin
                m_din = d[wi*DW +: DW];
                m_mem[m_add] = m_din;
            end else begin
                m_q.push_back('{due: cyc + 1, id: wi, data: m_mem[m_add]});
            end
            m_ptr = wi;
        end
        for (int j = 0; j < NR; j++) begin
            if (j == wi || !r[j]) wait_cnt[j] = 0;
            else if (wi >= 0) wait_cnt[j]++;
        end
        chk("ram_cs", ram_cs, m_cs);
        chk("ram_we", ram_we, m_we);
        chk("ram_oe", ram_oe, m_oe);
        chk("ram_add", ram_add, m_add);
        chk("ram_data_in", ram_data_in, m_din);
        exp_v = (m_q.size() > 0) && (m_q[0].due == cyc);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            chk("rsp_id", rsp_id, 64'(m_q[0].id));
            chk("rsp_data", rsp_data, m_q[0].data);
            void'(m_q.pop_front());
        end
        if (rsp_valid) begin
            rsp_got = 1'b1; rsp_got_id = int'(rsp_id);
            rsp_got_data = rsp_data; rsp_got_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        logic [NR-1:0] g;
        for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, g);
    endtask

    task automatic do_reset();
        req = '1; req_we = '0;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_oe", ram_oe, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_init_done", init_done, 0);
        m_ptr = NR - 1;
        m_q.delete();
        m_cs = 0; m_we = 0; m_oe = 0; m_add = '0; m_din = '0;
        for (int j = 0; j < NR; j++) wait_cnt[j] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_add", ram_add, 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_rsp_hold", rsp_valid, 0);
        rst = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        for (int e = 1; e <= RAM_SIZE; e++) begin
            @(posedge clk);
            #1;
            chk("clr_cs_we", {ram_cs, ram_we, ram_oe}, 3'b110);
            chk("clr_add", ram_add, 64'(e - 1));
            chk("clr_data", ram_data_in, 0);
            chk("clr_gnt", gnt, 0);
            chk("clr_init_done", init_done, 64'(e == RAM_SIZE));
        end
        for (int i = 0; i < RAM_SIZE; i++) m_mem[i] = '0;
        m_add = AW'(RAM_SIZE - 1);
`else
        @(posedge clk);
        #1;
        chk("init_done_rise", init_done, 1);
        chk("post_rst_cs", ram_cs, 0);
`endif
        req = '0;
    endtask

    vec_t          tbl [12];
    logic [NR-1:0] g;
    logic [NR-1:0] rr, rw;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    int            gcyc;

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1010, 4'b1000};
        tbl[3]  = '{4'b1010, 4'b0010};
        tbl[4]  = '{4'b0000, 4'b0000};
        tbl[5]  = '{4'b0001, 4'b0001};
        tbl[6]  = '{4'b0001, 4'b0001};
        tbl[7]  = '{4'b1100, 4'b0100};
        tbl[8]  = '{4'b0100, 4'b0100};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b1001, 4'b0001};
        tbl[11] = '{4'b0110, 4'b0010};
        for (int i = 0; i < RAM_SIZE; i++) m_mem[i] = '0;
        #1;
        do_reset();
        mem_init = 1'b0;

        // Grant order from reset pointer
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].r, '0, {6'd3, 6'd2, 6'd1, 6'd0}, '0, g);
            chk($sformatf("tbl_gnt_%0d", i), g, tbl[i].g);
        end
        idle(2);

        // Read address 9 after reset returns zero
        rsp_got = 1'b0;
        ra = '0; ra[0 +: AW] = 6'd9;
        cycle(4'b0001, '0, ra, '0, g);
        idle(2);
        chk("rd9_seen", rsp_got, 1);
        chk("rd9_data", rsp_got_data, 0);

        // Requester 2 writes 0xDEADBEEF to 0x3A, then reads it back
        ra = '0; ra[2*AW +: AW] = 6'h3A;
        rd = '0; rd[2*DW +: DW] = 32'hDEADBEEF;
        cycle(4'b0100, 4'b0100, ra, rd, g);
        rsp_got = 1'b0;
        cycle(4'b0100, 4'b0000, ra, '0, g);
        gcyc = cyc;
        idle(3);
        chk("beef_seen", rsp_got, 1);
        chk("beef_id", 64'(rsp_got_id), 2);
        chk("beef_data", rsp_got_data, 32'hDEADBEEF);
        chk("beef_latency", 64'(rsp_got_cyc - gcyc), 1);

        // Write then read on consecutive edges
        ra = '0; ra[1*AW +: AW] = 6'd7;
        rd = '0; rd[1*DW +: DW] = 32'h55;
        cycle(4'b0010, 4'b0010, ra, rd, g);
        rsp_got = 1'b0;
        cycle(4'b0010, 4'b0000, ra, '0, g);
        idle(2);
        chk("wr_rd_data", rsp_got_data, 32'h55);
        chk("wr_rd_id", 64'(rsp_got_id), 1);

        // Continuous read pressure from all requesters
        for (int i = 0; i < 8; i++) cycle(4'b1111, '0, {6'd7, 6'd3, 6'd9, 6'h3A}, '0, g);
        idle(2);

        // Randomized traffic with hold-until-grant requesters
        rr = '0; rw = '0; ra = '0; rd = '0;
        for (int t = 0; t < 400; t++) begin
            cycle(rr, rw, ra, rd, g);
            for (int j = 0; j < NR; j++) begin
                if (!rr[j] || g[j]) begin
                    rr[j] = ($urandom_range(0, 2) != 0);
                    rw[j] = 1'($urandom_range(0, 1));
                    ra[j*AW +: AW] = AW'($urandom_range(0, 7));
                    rd[j*DW +: DW] = $urandom;
                end else if ($urandom_range(0, 9) == 0) begin
                    rr[j] = 1'b0;
                end
            end
        end
        idle(2);

        // Reset one cycle after a read is accepted
        cycle(4'b0001, '0, {6'd0, 6'd0, 6'd0, 6'd9}, '0, g);
        do_reset();
        chk("rst_drop_rsp", rsp_valid, 0);
        for (int t = 0; t < 20; t++) begin
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  NR*AW'($urandom), {$urandom, $urandom, $urandom, $urandom}, g);
        end
        idle(3);
        chk("drain_empty", 64'(m_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
